// File: rtl/shifter_pipe_if.sv
// shifter_pipe_if
//   Groups the operation-in and result-out handshake channels of the
//   pipelined barrel shifter.
//   Signals:
//     in_valid/in_ready      operation handshake (ready driven by the shifter)
//     in_data [WIDTH]        operand
//     in_shamt[SHW]          shift amount, 0..WIDTH-1
//     in_op   [3]            000 SRL, 001 SRA, 010 SLL, 011 ROR, 100 ROL
//     out_valid/out_ready    result handshake (ready driven by the consumer)
//     out_data[WIDTH]        shifted result
//     out_err                result came from a reserved or disabled op
//     occupancy[SHW+1]       operations currently in flight
//   Modports: master = producer/consumer side, slave = shifter side.
interface shifter_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [SHW:0]     occupancy;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_err, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_err, occupancy
  );
endinterface

// File: rtl/shifter_pipe.sv
// shifter_pipe
//   Fully pipelined barrel shifter: SRL, SRA, SLL and (optionally) ROR/ROL on
//   WIDTH-bit operands. Layer k shifts by 2^k when shamt bit k is set, so the
//   pipe is log2(WIDTH) registered layers deep and accepts one op per cycle.
//   The whole pipe stalls together: it advances whenever the last layer is
//   empty or the consumer takes the result.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (release synchronous to clk)
//     bus    shifter_pipe_if.slave (operation in, result out, occupancy)
//   Build option:
//     SHIFTER_ROTATE_EN  when defined, ops 011 (ROR) and 100 (ROL) rotate;
//                        when undefined they are reserved (pass-through,
//                        out_err = 1) and no wrap logic is built.
//   WIDTH must match the WIDTH of the connected interface instance.
module shifter_pipe #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  shifter_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0]   OP_SRL  = 3'b000;
  localparam logic [2:0]   OP_SRA  = 3'b001;
  localparam logic [2:0]   OP_SLL  = 3'b010;
  localparam logic [2:0]   OP_ROR  = 3'b011;
  localparam logic [2:0]   OP_ROL  = 3'b100;
  localparam logic [SHW:0] OCC_ONE = {{SHW{1'b0}}, 1'b1};

  logic         advance;
  logic         accept;
  logic         xfer;
  logic         in_err;
  logic [SHW:0] occ_reg;
  logic [SHW:0] occ_next;

  // Layer registers. The last layer only needs data/valid/err, so the
  // side-band fields (op, SRA fill bit, shift amount) stop one layer short.
  logic [WIDTH-1:0] data_reg  [SHW];
  logic             valid_reg [SHW];
  logic             err_reg   [SHW];
  logic [2:0]       op_reg    [SHW-1];
  logic             msb_reg   [SHW-1];
  logic [SHW-1:0]   shamt_reg [SHW-1];

  // What each layer sees on its input, and its shifted result.
  logic [WIDTH-1:0] data_in   [SHW];
  logic [WIDTH-1:0] data_next [SHW];
  logic             valid_in  [SHW];
  logic             err_in    [SHW];
  logic             msb_in    [SHW];
  logic [2:0]       op_in     [SHW];
  logic [SHW-1:0]   shamt_in  [SHW];

  assign advance = !valid_reg[SHW-1] || bus.out_ready;
  assign accept  = bus.in_valid && advance;
  assign xfer    = valid_reg[SHW-1] && bus.out_ready;

`ifdef SHIFTER_ROTATE_EN
  assign in_err = (bus.in_op > OP_ROL);
`else
  assign in_err = (bus.in_op > OP_SLL);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_layer
      localparam int STEP = 1 << gi;
      logic [WIDTH-1:0] shifted;

      if (gi == 0) begin : g_head
        // Bubbles enter as all-zero slots so idle data stays deterministic.
        assign data_in[gi]  = accept ? bus.in_data : '0;
        assign valid_in[gi] = accept;
        assign err_in[gi]   = accept && in_err;
        assign msb_in[gi]   = accept && bus.in_data[WIDTH-1];
        assign op_in[gi]    = accept ? bus.in_op : OP_SRL;
        assign shamt_in[gi] = accept ? bus.in_shamt : '0;
      end else begin : g_body
        assign data_in[gi]  = data_reg[gi-1];
        assign valid_in[gi] = valid_reg[gi-1];
        assign err_in[gi]   = err_reg[gi-1];
        assign msb_in[gi]   = msb_reg[gi-1];
        assign op_in[gi]    = op_reg[gi-1];
        assign shamt_in[gi] = shamt_reg[gi-1];
      end

      always_comb begin
        shifted = data_in[gi];
        // Reserved ops never shift, so they arrive at the output unchanged.
        if (shamt_in[gi][gi] && !err_in[gi]) begin
          case (op_in[gi])
            OP_SRL:  shifted = data_in[gi] >> STEP;
            // SRA fills from the operand MSB captured at the input layer.
            OP_SRA:  shifted = (data_in[gi] >> STEP) |
                               ({WIDTH{msb_in[gi]}} << (WIDTH - STEP));
            OP_SLL:  shifted = data_in[gi] << STEP;
`ifdef SHIFTER_ROTATE_EN
            OP_ROR:  shifted = (data_in[gi] >> STEP) | (data_in[gi] << (WIDTH - STEP));
            OP_ROL:  shifted = (data_in[gi] << STEP) | (data_in[gi] >> (WIDTH - STEP));
`endif
            default: shifted = data_in[gi];
          endcase
        end
      end

      assign data_next[gi] = shifted;
    end
  endgenerate

  always_comb begin
    occ_next = occ_reg;
    if (accept && !xfer) begin
      occ_next = occ_reg + OCC_ONE;
    end else if (xfer && !accept) begin
      occ_next = occ_reg - OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        data_reg[k]  <= '0;
        valid_reg[k] <= 1'b0;
        err_reg[k]   <= 1'b0;
      end
      for (int k = 0; k < SHW - 1; k++) begin
        op_reg[k]    <= OP_SRL;
        msb_reg[k]   <= 1'b0;
        shamt_reg[k] <= '0;
      end
      occ_reg <= '0;
    end else begin
      if (advance) begin
        for (int k = 0; k < SHW; k++) begin
          data_reg[k]  <= data_next[k];
          valid_reg[k] <= valid_in[k];
          err_reg[k]   <= err_in[k];
        end
        for (int k = 0; k < SHW - 1; k++) begin
          op_reg[k]    <= op_in[k];
          msb_reg[k]   <= msb_in[k];
          shamt_reg[k] <= shamt_in[k];
        end
      end
      occ_reg <= occ_next;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_reg[SHW-1];
  assign bus.out_data  = data_reg[SHW-1];
  assign bus.out_err   = err_reg[SHW-1];
  assign bus.occupancy = occ_reg;
endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;
  logic clk = 1'b0;
  logic rst_n;

  shifter_pipe_if #(.WIDTH(32)) bus ();

  shifter_pipe #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;

  logic [31:0] vd [8];
  logic [4:0]  vs [8];
  logic [2:0]  vo [8];

  // Reference: plain-arithmetic meaning of each op. Returns {err, data}.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] sh,
                                        input logic [2:0] op);
    logic [63:0] dd;
    logic [63:0] rot;
    logic [31:0] sra;
    dd  = {d, d};
    sra = $signed(d) >>> sh;
    case (op)
      3'd0: return {1'b0, d >> sh};
      3'd1: return {1'b0, sra};
      3'd2: return {1'b0, d << sh};
`ifdef SHIFTER_ROTATE_EN
      3'd3: begin rot = dd >> sh; return {1'b0, rot[31:0]}; end
      3'd4: begin rot = dd << sh; return {1'b0, rot[63:32]}; end
`endif
      default: return {1'b1, d};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: scoreboard of accepted ops vs. delivered results.
  logic [32:0] exp_q [$];
  initial begin
    logic        hold_prev;
    logic [31:0] hold_data;
    logic        hold_err;
    logic [32:0] e;
    hold_prev = 1'b0;
    hold_data = '0;
    hold_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        hold_prev = 1'b0;
      end else begin
        check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
        check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
        if (hold_prev) begin
          check("hold_valid", 64'(bus.out_valid), 64'(1));
          check("hold_data", 64'(bus.out_data), 64'(hold_data));
          check("hold_err", 64'(bus.out_err), 64'(hold_err));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_result", 64'(bus.out_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            n_xfer++;
            $display("xfer %0d: data=%h err=%b expect data=%h err=%b",
                     n_xfer, bus.out_data, bus.out_err, e[31:0], e[32]);
            check("result_data", 64'(bus.out_data), 64'(e[31:0]));
            check("result_err", 64'(bus.out_err), 64'(e[32]));
          end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_err  = bus.out_err;
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.in_data, bus.in_shamt, bus.in_op));
        end
      end
    end
  end

  // One op into an empty pipe; checks literal result and 5-cycle latency.
  task automatic run_one(input string name, input logic [31:0] d, input logic [4:0] sh,
                         input logic [2:0] op, input logic [31:0] exp_d, input logic exp_e);
    int lat;
    check({name, "_model"}, 64'(model(d, sh, op)), 64'({exp_e, exp_d}));
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_op    = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(5));
    check({name, "_data"}, 64'(bus.out_data), 64'(exp_d));
    check({name, "_err"}, 64'(bus.out_err), 64'(exp_e));
    @(posedge clk); #1;
  endtask

  // Eight ops offered back to back, optional out_ready stall window.
  task automatic stream(input int stall_at, input int stall_len);
    int sent;
    int got;
    logic [31:0] frozen;
    sent = 0;
    got = 0;
    frozen = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus.out_ready = !(c >= stall_at && c < stall_at + stall_len);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = vd[sent];
        bus.in_shamt = vs[sent];
        bus.in_op    = vo[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (stall_len == 0) begin
        check("stream_valid", 64'(bus.out_valid), 64'(c >= 5 && c <= 12));
      end else if (c >= stall_at && c < stall_at + stall_len) begin
        check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        check("stall_occupancy", 64'(bus.occupancy), 64'(5));
        if (c == stall_at) frozen = bus.out_data;
        else check("stall_data", 64'(bus.out_data), 64'(frozen));
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) got++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count", 64'(got), 64'(8));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vd = '{32'hDEADBEEF, 32'h80000001, 32'h0F0F0F0F, 32'hFFFF0000,
           32'h12345678, 32'hA5A5A5A5, 32'h00000001, 32'h7FFFFFFF};
    vs = '{5'd1, 5'd31, 5'd8, 5'd16, 5'd0, 5'd13, 5'd5, 5'd27};
    vo = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd7, 3'd2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_err", 64'(bus.out_err), 64'(0));
    check("rst_occupancy", 64'(bus.occupancy), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));

    run_one("sra4", 32'h80000000, 5'd4, 3'd1, 32'hF8000000, 1'b0);
    run_one("srl4", 32'h80000000, 5'd4, 3'd0, 32'h08000000, 1'b0);
    run_one("sll31", 32'h00000001, 5'd31, 3'd2, 32'h80000000, 1'b0);
`ifdef SHIFTER_ROTATE_EN
    run_one("ror4", 32'h0000000F, 5'd4, 3'd3, 32'hF0000000, 1'b0);
    run_one("rol1", 32'h80000001, 5'd1, 3'd4, 32'h00000003, 1'b0);
    run_one("ror0", 32'h12345678, 5'd0, 3'd3, 32'h12345678, 1'b0);
`else
    run_one("ror4", 32'h0000000F, 5'd4, 3'd3, 32'h0000000F, 1'b1);
    run_one("rol1", 32'h80000001, 5'd1, 3'd4, 32'h80000001, 1'b1);
    run_one("ror0", 32'h12345678, 5'd0, 3'd3, 32'h12345678, 1'b1);
`endif
    run_one("op7", 32'h12345678, 5'd7, 3'd7, 32'h12345678, 1'b1);
    run_one("op5", 32'hCAFEF00D, 5'd3, 3'd5, 32'hCAFEF00D, 1'b1);
    run_one("sra0", 32'h80000000, 5'd0, 3'd1, 32'h80000000, 1'b0);
    run_one("sra31", 32'h80000000, 5'd31, 3'd1, 32'hFFFFFFFF, 1'b0);

    stream(-1, 0);
    stream(6, 3);

    // Reset with three ops in flight.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11111111 * (c + 1);
      bus.in_shamt = 5'(c);
      bus.in_op    = 3'd2;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2;
    check("pre_rst_occupancy", 64'(bus.occupancy), 64'(3));
    rst_n = 1'b0;
    #1;
    check("async_rst_occupancy", 64'(bus.occupancy), 64'(0));
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_out_data", 64'(bus.out_data), 64'(0));
    check("async_rst_out_err", 64'(bus.out_err), 64'(0));
    check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_rst_no_stale", 64'(bus.out_valid), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
